// File: rtl/sha256_uart_pkg.sv
// Shared types, constants and the nibble-to-ASCII helper for the SHA-256 digest UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sha256_uart_pkg;

    // Union of the parent (IDLE/LOAD/STOP/DONE) and serialiser (IDLE/START/DATA/STOP) states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // 27 MHz board clock / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 234;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Lowercase hex digit for one nibble: 0-9 -> '0'-'9', 10-15 -> 'a'-'f'
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h57 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/sha256_digest_tx_uart.sv
// 8N1 UART byte serialiser with a valid/ready byte input.
// Latency: start bit on the line the cycle after a byte is accepted; frame = 10*CLKS_PER_BIT cycles.
// Backpressure: o_byte_rdy high when idle or in the last stop-bit cycle, so frames can run back to back.
module uart_tx_8n1
    import sha256_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_byte_vld,
    input  logic [7:0] i_byte_dat,
    output logic       o_byte_rdy,
    output logic       o_uart_tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [CW-1:0] r_baud;
    logic [CW-1:0] w_baud_nxt;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    r_byte;
    logic [7:0]    w_byte_nxt;
    logic          r_tx;
    logic          w_tx_nxt;
    logic          w_bit_end;

    assign w_bit_end  = (r_baud == BAUD_LAST);
    // Accepting in the final stop-bit cycle is what removes the inter-frame gap
    assign o_byte_rdy = (r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end);
    assign o_uart_tx  = r_tx;

    // Next-state, counter reloads and the registered line level
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = w_bit_end ? '0 : r_baud + 1'b1;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        case (r_state)
            ST_IDLE: begin
                w_baud_nxt = '0;
                w_bit_nxt  = 3'd0;
                if (i_byte_vld) begin
                    w_state_nxt = ST_START;
                    w_byte_nxt  = i_byte_dat;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                    w_bit_nxt   = 3'd0;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == 3'd7) begin
                        w_state_nxt = ST_STOP;
                        w_bit_nxt   = 3'd0;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (i_byte_vld) begin
                        w_state_nxt = ST_START;
                        w_byte_nxt  = i_byte_dat;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_baud_nxt  = '0;
                w_bit_nxt   = 3'd0;
            end
        endcase

        // Line is driven from a flop so it cannot glitch; only START/DATA ever pull it low
        if (w_state_nxt == ST_START) begin
            w_tx_nxt = 1'b0;
        end else if (w_state_nxt == ST_DATA) begin
            w_tx_nxt = w_byte_nxt[w_bit_nxt];
        end else begin
            w_tx_nxt = 1'b1;
        end
    end

    // State, counters, shift byte and line register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_byte  <= 8'h00;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_byte  <= w_byte_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

endmodule

// File: rtl/sha256_digest_tx.sv
// Sends a captured 256-bit SHA-256 digest over an 8N1 UART, as 64 hex chars + CR LF or as 32 raw bytes.
// Latency: first start bit the cycle after capture; done pulses the cycle after the last stop bit.
// Backpressure: digest_ready only in IDLE/DONE; digest and digest_valid are ignored while busy.
module sha256_digest_tx
    import sha256_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int ASCII_HEX    = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] digest,
    input  logic         digest_valid,
    output logic         digest_ready,
    output logic         uart_tx,
    output logic         busy,
    output logic         done
);

    localparam int         NCHARS    = (ASCII_HEX != 0) ? 66 : 32;
    localparam logic [6:0] LAST_CHAR = 7'(NCHARS - 1);

    state_e       r_state;
    state_e       w_state_nxt;
    logic [255:0] r_digest;
    logic [6:0]   r_char;
    logic [7:0]   w_char_reg;
    logic [7:0]   w_char_first;
    logic         w_byte_vld;
    logic [7:0]   w_byte_dat;
    logic         w_byte_rdy;
    logic         w_accept;

    assign w_accept = digest_valid && digest_ready;

    uart_tx_8n1 #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_byte_vld (w_byte_vld),
        .i_byte_dat (w_byte_dat),
        .o_byte_rdy (w_byte_rdy),
        .o_uart_tx  (uart_tx)
    );

    // Character selection: char 0 comes straight from the input so the serialiser can start on the
    // capture edge; later chars come from the captured copy indexed by the char counter
    always_comb begin
        w_char_reg   = 8'h00;
        w_char_first = 8'h00;
        if (ASCII_HEX != 0) begin
            w_char_first = nib2ascii(digest[255:252]);
            if (r_char == 7'd64) begin
                w_char_reg = ASCII_CR;
            end else if (r_char == 7'd65) begin
                w_char_reg = ASCII_LF;
            end else begin
                w_char_reg = nib2ascii(r_digest[{~r_char[5:0], 2'b00} +: 4]);
            end
        end else begin
            w_char_first = digest[255:248];
            w_char_reg   = r_digest[{~r_char[4:0], 3'b000} +: 8];
        end
    end

    // Parent FSM: LOAD offers chars to the serialiser, STOP waits out the final frame
    always_comb begin
        w_state_nxt  = r_state;
        w_byte_vld   = 1'b0;
        w_byte_dat   = w_char_reg;
        digest_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                // The serialiser is always idle here, so a handshake starts it immediately
                digest_ready = 1'b1;
                done         = (r_state == ST_DONE);
                w_state_nxt  = ST_IDLE;
                if (digest_valid) begin
                    w_byte_vld  = 1'b1;
                    w_byte_dat  = w_char_first;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy       = 1'b1;
                w_byte_vld = 1'b1;
                if (w_byte_rdy && (r_char == LAST_CHAR)) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                busy = 1'b1;
                if (w_byte_rdy) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Digest capture and char counter; the counter parks on the last char and never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digest <= '0;
            r_char   <= 7'd0;
        end else if (w_accept) begin
            r_digest <= digest;
            r_char   <= 7'd1;
        end else if ((r_state == ST_LOAD) && w_byte_rdy && (r_char != LAST_CHAR)) begin
            r_char <= r_char + 7'd1;
        end else if ((r_state == ST_STOP) && w_byte_rdy) begin
            r_char <= 7'd0;
        end
    end

endmodule

// File: tb/tb_sha256_digest_tx.sv
// Self-checking bench: UART receiver model feeding a scoreboard, table-driven digests, reset/back-to-back corners.
// Latency: n/a.
// Backpressure: n/a.
module tb_sha256_digest_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] digest = '0;
    logic         vld_hex = 1'b0;
    logic         vld_raw = 1'b0;
    logic         rdy_hex, tx_hex, busy_hex, done_hex;
    logic         rdy_raw, tx_raw, busy_raw, done_raw;

    always #5 clk = ~clk;

    sha256_digest_tx #(.CLKS_PER_BIT(CPB), .ASCII_HEX(1)) dut_hex (
        .clk(clk), .rst(rst), .digest(digest), .digest_valid(vld_hex),
        .digest_ready(rdy_hex), .uart_tx(tx_hex), .busy(busy_hex), .done(done_hex));

    sha256_digest_tx #(.CLKS_PER_BIT(CPB), .ASCII_HEX(0)) dut_raw (
        .clk(clk), .rst(rst), .digest(digest), .digest_valid(vld_raw),
        .digest_ready(rdy_raw), .uart_tx(tx_raw), .busy(busy_raw), .done(done_raw));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_frames = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    bit         sel_raw = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- UART receiver + scoreboard ----------------
    bit         rx_on = 1'b0;
    int         rx_cnt = 0;
    int         rx_bi;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rx_exp;
    logic       rx_line;

    always @(negedge clk) begin
        rx_line = sel_raw ? tx_raw : tx_hex;
        if (rst) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (rx_line == 1'b0) begin
                rx_on  = 1'b1;
                rx_cnt = 0;
                start_q.push_back(cyc);
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == CPB / 2) begin
                chk("rx_start_bit", rx_line, 0);
            end else if (rx_cnt < 9 * CPB && (rx_cnt % CPB) == CPB / 2) begin
                rx_bi = rx_cnt / CPB - 1;
                rx_byte[rx_bi[2:0]] = rx_line;
            end else if (rx_cnt == 9 * CPB + CPB / 2) begin
                chk("rx_stop_bit", rx_line, 1);
                n_frames++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL rx_unexpected: got 0x%02h, expected no frame", rx_byte);
                end else begin
                    rx_exp = exp_q.pop_front();
                    if (rx_byte !== rx_exp) begin
                        n_errors++;
                        $display("FAIL rx_char: got 0x%02h, expected 0x%02h (cycle %0d)", rx_byte, rx_exp, cyc);
                    end
                end
                rx_on = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] hexc(input logic [3:0] n);
        string h;
        h = "0123456789abcdef";
        return h[int'(n)];
    endfunction

    task automatic push_expected(input bit raw, input logic [255:0] d);
        logic [255:0] t;
        if (!raw) begin
            for (int i = 0; i < 64; i++) begin
                t = d >> (4 * (63 - i));
                exp_q.push_back(hexc(t[3:0]));
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end else begin
            for (int i = 0; i < 32; i++) begin
                t = d >> (8 * (31 - i));
                exp_q.push_back(t[7:0]);
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send(input bit raw, input logic [255:0] d, input bit use_model, output int cap);
        int k;
        k = 0;
        @(negedge clk);
        while (((raw ? rdy_raw : rdy_hex) == 1'b0) && k < 10000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 10000) chk("ready_timeout", 0, 1);
        @(posedge clk); #1;
        digest = d;
        if (raw) vld_raw = 1'b1; else vld_hex = 1'b1;
        if (use_model) push_expected(raw, d);
        @(posedge clk); #1;
        vld_raw = 1'b0;
        vld_hex = 1'b0;
        cap = cyc;
    endtask

    task automatic wait_done(input bit raw, output int dcyc);
        int k;
        k = 0;
        dcyc = -1;
        while (k < 6000) begin
            @(negedge clk);
            if ((raw ? done_raw : done_hex) == 1'b1) begin
                dcyc = cyc;
                break;
            end
            k++;
        end
        if (dcyc < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic run_vec(input bit raw, input logic [255:0] d, input int nchars, input int lat, input bit use_model);
        int cap, dcyc;
        start_q.delete();
        sel_raw = raw;
        send(raw, d, use_model, cap);
        chk("busy_after_capture", raw ? busy_raw : busy_hex, 1);
        wait_done(raw, dcyc);
        chk("done_latency", dcyc - cap, lat);
        chk("ready_in_done", raw ? rdy_raw : rdy_hex, 1);
        chk("busy_in_done", raw ? busy_raw : busy_hex, 0);
        chk("frame_count", start_q.size(), nchars);
        if (start_q.size() == nchars) begin
            chk("first_start", start_q[0], cap);
            chk("frame_span", start_q[nchars-1] - start_q[0], (nchars - 1) * FRAME);
        end
        @(negedge clk);
        chk("done_single", raw ? done_raw : done_hex, 0);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    typedef struct {
        bit           raw;
        logic [255:0] d;
        int           nchars;
        int           lat;
    } vec_t;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vt[5];
        string        abc;
        logic [255:0] d_a, d_b;
        int           cap, cap_b, dcyc, fr0, bad, target;

        vt[0] = '{1'b0, 256'h0, 66, 66 * FRAME};
        vt[1] = '{1'b0, {256{1'b1}}, 66, 66 * FRAME};
        vt[2] = '{1'b0, 256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0, 66, 66 * FRAME};
        vt[3] = '{1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 32, 32 * FRAME};
        vt[4] = '{1'b1, {16{16'hA55A}}, 32, 32 * FRAME};

        // reset: 3 cycles high
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_hex", tx_hex, 1);
        chk("rst_ready_hex", rdy_hex, 1);
        chk("rst_busy_hex", busy_hex, 0);
        chk("rst_done_hex", done_hex, 0);
        chk("rst_tx_raw", tx_raw, 1);
        chk("rst_ready_raw", rdy_raw, 1);
        chk("rst_busy_raw", busy_raw, 0);
        chk("rst_done_raw", done_raw, 0);

        // known SHA-256("abc") line, expectations taken from the literal text
        abc = "ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad\r\n";
        for (int i = 0; i < abc.len(); i++) exp_q.push_back(abc[i]);
        run_vec(1'b0, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 66, 2640, 1'b0);

        // table-driven digests through both formats
        for (int i = 0; i < 5; i++) begin
            run_vec(vt[i].raw, vt[i].d, vt[i].nchars, vt[i].lat, 1'b1);
        end

        // new digest and valid pulse mid-transmission are ignored
        sel_raw = 1'b0;
        start_q.delete();
        d_a = 256'h5555aaaa0123456789abcdef00ff00ff13579bdf2468ace0deadbeefcafef00d;
        send(1'b0, d_a, 1'b1, cap);
        repeat (300) @(negedge clk);
        chk("ignore_ready_low", rdy_hex, 0);
        @(posedge clk); #1;
        digest  = ~d_a;
        vld_hex = 1'b1;
        @(posedge clk); #1;
        vld_hex = 1'b0;
        @(negedge clk);
        chk("ignore_ready_stays_low", rdy_hex, 0);
        chk("ignore_busy", busy_hex, 1);
        wait_done(1'b0, dcyc);
        chk("ignore_done_latency", dcyc - cap, 2640);
        chk("ignore_sb_empty", exp_q.size(), 0);

        // back-to-back: second digest held valid across the done cycle
        start_q.delete();
        d_a = 256'h1111222233334444555566667777888899990000aaaabbbbccccddddeeeeffff;
        d_b = 256'hfedcba9876543210fedcba9876543210fedcba9876543210fedcba9876543210;
        send(1'b0, d_a, 1'b1, cap);
        @(posedge clk); #1;
        digest  = d_b;
        vld_hex = 1'b1;
        push_expected(1'b0, d_b);
        wait_done(1'b0, dcyc);
        chk("b2b_first_done", dcyc - cap, 2640);
        chk("b2b_ready_in_done", rdy_hex, 1);
        @(posedge clk); #1;
        vld_hex = 1'b0;
        cap_b = cyc;
        @(negedge clk);
        chk("b2b_busy_next", busy_hex, 1);
        chk("b2b_ready_next", rdy_hex, 0);
        chk("b2b_done_next", done_hex, 0);
        wait_done(1'b0, dcyc);
        chk("b2b_second_done", dcyc - cap_b, 2640);
        chk("b2b_frame_count", start_q.size(), 132);
        if (start_q.size() == 132) begin
            // the done cycle is the only high cycle between the two digests
            chk("b2b_second_start", start_q[66], cap + 2641);
            chk("b2b_gap", start_q[66] - start_q[65], FRAME + 1);
        end
        chk("b2b_sb_empty", exp_q.size(), 0);

        // reset during char 10, data bit 3
        start_q.delete();
        fr0 = n_frames;
        send(1'b0, 256'hc0ffee00112233445566778899aabbccddeeff0123456789abcdef0011223344, 1'b1, cap);
        target = cap + 10 * FRAME + 4 * CPB;
        while (cyc < target) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_tx_high", tx_hex, 1);
        chk("midrst_busy", busy_hex, 0);
        chk("midrst_ready", rdy_hex, 1);
        chk("midrst_done", done_hex, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_hex || !tx_hex) bad++;
        end
        chk("midrst_quiet", bad, 0);
        chk("midrst_frames_before_abort", n_frames - fr0, 10);
        exp_q.delete();
        run_vec(1'b0, 256'h0f0e0d0c0b0a09080706050403020100f0e0d0c0b0a090807060504030201000, 66, 2640, 1'b1);

        // reset wins over a simultaneous handshake
        fr0 = n_frames;
        @(posedge clk); #1;
        rst     = 1'b1;
        vld_hex = 1'b1;
        digest  = {8{32'h12345678}};
        @(posedge clk); #1;
        rst     = 1'b0;
        vld_hex = 1'b0;
        @(negedge clk);
        chk("rstprio_busy", busy_hex, 0);
        chk("rstprio_ready", rdy_hex, 1);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!tx_hex || busy_hex) bad++;
        end
        chk("rstprio_no_tx", bad, 0);
        chk("rstprio_frames", n_frames - fr0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
